// File: rtl/lockstep_stagger.sv
// Staggered-lockstep unit: one leader hart drives the OBI bus, follower harts
// replay the leader's responses, interrupts and debug requests after
// rank*NCYCLES cycles and have their own requests checked against the
// leader's delayed request stream.

package lockstep_stagger_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module lockstep_stagger
    import lockstep_stagger_pkg::*;
#(
    parameter int NHARTS  = 3,
    parameter int NCYCLES = 2,
    parameter int LW      = $clog2(NHARTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [LW-1:0]     leader_i,
    input  logic              clear_i,

    input  obi_req_t          core_instr_req_i  [NHARTS],
    output obi_req_t          core_instr_req_o  [NHARTS],
    input  obi_resp_t         core_instr_resp_i [NHARTS],
    output obi_resp_t         core_instr_resp_o [NHARTS],

    input  obi_req_t          core_data_req_i   [NHARTS],
    output obi_req_t          core_data_req_o   [NHARTS],
    input  obi_resp_t         core_data_resp_i  [NHARTS],
    output obi_resp_t         core_data_resp_o  [NHARTS],

    input  logic [31:0]       intr_i            [NHARTS],
    output logic [31:0]       intr_o            [NHARTS],
    input  logic [NHARTS-1:0] debug_i,
    output logic [NHARTS-1:0] debug_o,

    output logic [NHARTS-1:0] mismatch_o,
    output logic              mismatch_any_o
);

    // Deepest tap needed: the highest-ranked follower.
    localparam int DMAX = (NHARTS - 1) * NCYCLES;

    // One snapshot of the leader's port activity on a single channel.
    typedef struct packed {
        logic        hs;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } dl_entry_t;

    // One snapshot of the leader's interrupt and debug lines.
    typedef struct packed {
        logic [31:0] intr;
        logic        debug;
    } irq_entry_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Capture the leader's request/response pair as a delay-line entry.
    function automatic dl_entry_t make_entry(input obi_req_t rq, input obi_resp_t rs);
        dl_entry_t e;
        e.hs     = rq.req & rs.gnt;
        e.we     = rq.we;
        e.be     = rq.be;
        e.addr   = rq.addr;
        e.wdata  = rq.wdata;
        e.gnt    = rs.gnt;
        e.rvalid = rs.rvalid;
        e.rdata  = rs.rdata;
        return e;
    endfunction

    // Response seen by a follower core: the replayed part of a tap.
    function automatic obi_resp_t tap_resp(input dl_entry_t e);
        obi_resp_t r;
        r.gnt    = e.gnt;
        r.rvalid = e.rvalid;
        r.rdata  = e.rdata;
        return r;
    endfunction

    // Divergence of a follower's request against the leader's delayed one.
    // A follower request without any delayed leader handshake or grant is
    // treated as spurious.
    function automatic logic chan_err(input dl_entry_t t, input obi_req_t f);
        logic diverge;
        logic spurious;
        diverge  = !f.req
                 || (f.addr != t.addr)
                 || (f.we   != t.we)
                 || (f.be   != t.be)
                 || (t.we && (f.wdata != t.wdata));
        spurious = f.req && !t.hs && !t.gnt;
        return (t.hs && diverge) || spurious;
    endfunction

    // Rank of hart idx relative to the leader: (idx - lead) mod NHARTS.
    function automatic logic [LW-1:0] rank_of(input int idx, input logic [LW-1:0] lead);
        int d;
        d = idx - int'(lead);
        if (d < 0) begin
            d = d + NHARTS;
        end
        return LW'(d);
    endfunction

    // ------------------------------------------------------------------
    // Mode and leader registers
    // ------------------------------------------------------------------

    logic          enable_q;
    logic [LW-1:0] leader_q;
    logic          enable_rise;
    logic          dl_run;

    assign enable_rise = enable_i & ~enable_q;
    // Lines only shift while lockstep is active and stays active; a falling
    // enable_i or bypass mode loads zeros so stale replies are dropped.
    assign dl_run      = enable_q & enable_i;

    // Track the mode and latch the leader only when lockstep is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q <= 1'b0;
            leader_q <= '0;
        end else begin
            enable_q <= enable_i;
            if (enable_rise) begin
                // An out-of-range leader index falls back to hart 0.
                leader_q <= (int'(leader_i) < NHARTS) ? leader_i : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Delay lines, stage k holds what the leader did k cycles ago
    // ------------------------------------------------------------------

    obi_req_t   lead_ireq;
    obi_resp_t  lead_iresp;
    obi_req_t   lead_dreq;
    obi_resp_t  lead_dresp;
    irq_entry_t lead_irq;

    assign lead_ireq      = core_instr_req_i[leader_q];
    assign lead_iresp     = core_instr_resp_i[leader_q];
    assign lead_dreq      = core_data_req_i[leader_q];
    assign lead_dresp     = core_data_resp_i[leader_q];
    assign lead_irq.intr  = intr_i[leader_q];
    assign lead_irq.debug = debug_i[leader_q];

    dl_entry_t  instr_dl_q [1:DMAX];
    dl_entry_t  data_dl_q  [1:DMAX];
    irq_entry_t irq_dl_q   [1:DMAX];

    // Shift the leader's activity through all three lines, or flush them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 1; k <= DMAX; k++) begin
                instr_dl_q[k] <= '0;
                data_dl_q[k]  <= '0;
                irq_dl_q[k]   <= '0;
            end
        end else if (!dl_run) begin
            for (int k = 1; k <= DMAX; k++) begin
                instr_dl_q[k] <= '0;
                data_dl_q[k]  <= '0;
                irq_dl_q[k]   <= '0;
            end
        end else begin
            instr_dl_q[1] <= make_entry(lead_ireq, lead_iresp);
            data_dl_q[1]  <= make_entry(lead_dreq, lead_dresp);
            irq_dl_q[1]   <= lead_irq;
            for (int k = 2; k <= DMAX; k++) begin
                instr_dl_q[k] <= instr_dl_q[k-1];
                data_dl_q[k]  <= data_dl_q[k-1];
                irq_dl_q[k]   <= irq_dl_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-rank taps: rank r reads stage r*NCYCLES; rank 0 never uses one
    // ------------------------------------------------------------------

    dl_entry_t  instr_tap [NHARTS];
    dl_entry_t  data_tap  [NHARTS];
    irq_entry_t irq_tap   [NHARTS];

    assign instr_tap[0] = '0;
    assign data_tap[0]  = '0;
    assign irq_tap[0]   = '0;

    genvar gi;
    for (gi = 1; gi < NHARTS; gi++) begin : g_tap
        assign instr_tap[gi] = instr_dl_q[gi*NCYCLES];
        assign data_tap[gi]  = data_dl_q[gi*NCYCLES];
        assign irq_tap[gi]   = irq_dl_q[gi*NCYCLES];
    end

    // ------------------------------------------------------------------
    // Per-hart routing and divergence check
    // ------------------------------------------------------------------

    logic [NHARTS-1:0] err;

    for (gi = 0; gi < NHARTS; gi++) begin : g_hart
        logic [LW-1:0] rank;
        logic          follower;
        dl_entry_t     itap;
        dl_entry_t     dtap;
        irq_entry_t    qtap;

        assign rank     = rank_of(gi, leader_q);
        assign follower = enable_q && (rank != '0);
        assign itap     = instr_tap[rank];
        assign dtap     = data_tap[rank];
        assign qtap     = irq_tap[rank];

        // Followers are cut off from the bus and fed from their tap; the
        // leader and every hart in bypass pass straight through.
        assign core_instr_req_o[gi]  = follower ? '0               : core_instr_req_i[gi];
        assign core_data_req_o[gi]   = follower ? '0               : core_data_req_i[gi];
        assign core_instr_resp_o[gi] = follower ? tap_resp(itap)   : core_instr_resp_i[gi];
        assign core_data_resp_o[gi]  = follower ? tap_resp(dtap)   : core_data_resp_i[gi];
        assign intr_o[gi]            = follower ? qtap.intr        : intr_i[gi];
        assign debug_o[gi]           = follower ? qtap.debug       : debug_i[gi];

        // Either channel diverging flags the hart; both at once flag it once.
        assign err[gi] = follower
                       && (chan_err(itap, core_instr_req_i[gi])
                           || chan_err(dtap, core_data_req_i[gi]));
    end

    // ------------------------------------------------------------------
    // Sticky mismatch flags
    // ------------------------------------------------------------------

    logic [NHARTS-1:0] mismatch_q;

    // Clear drops old flags, but a new error in the same cycle still sets.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch_q <= '0;
        end else begin
            mismatch_q <= (clear_i ? '0 : mismatch_q) | err;
        end
    end

    assign mismatch_o     = mismatch_q;
    assign mismatch_any_o = |mismatch_q;

endmodule

// File: tb/tb_lockstep_stagger.sv
// Directed bench for lockstep_stagger (NHARTS=3, NCYCLES=2): a vector table
// for the lockstep replay timing plus hand sequences for bypass, divergence,
// spurious requests, leader rotation, flush and asynchronous reset.

module tb_lockstep_stagger;
    import lockstep_stagger_pkg::*;

    localparam int NH = 3;
    localparam int NC = 2;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [LW-1:0] leader = '0;

    obi_req_t    ireq_i  [NH];
    obi_req_t    ireq_o  [NH];
    obi_resp_t   iresp_i [NH];
    obi_resp_t   iresp_o [NH];
    obi_req_t    dreq_i  [NH];
    obi_req_t    dreq_o  [NH];
    obi_resp_t   dresp_i [NH];
    obi_resp_t   dresp_o [NH];
    logic [31:0] intr_i  [NH];
    logic [31:0] intr_o  [NH];
    logic [NH-1:0] dbg_i;
    logic [NH-1:0] dbg_o;
    logic [NH-1:0] mm;
    logic          mm_any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lockstep_stagger #(
        .NHARTS  (NH),
        .NCYCLES (NC)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .enable_i          (enable),
        .leader_i          (leader),
        .clear_i           (clear),
        .core_instr_req_i  (ireq_i),
        .core_instr_req_o  (ireq_o),
        .core_instr_resp_i (iresp_i),
        .core_instr_resp_o (iresp_o),
        .core_data_req_i   (dreq_i),
        .core_data_req_o   (dreq_o),
        .core_data_resp_i  (dresp_i),
        .core_data_resp_o  (dresp_o),
        .intr_i            (intr_i),
        .intr_o            (intr_o),
        .debug_i           (dbg_i),
        .debug_o           (dbg_o),
        .mismatch_o        (mm),
        .mismatch_any_o    (mm_any)
    );

    // One row per cycle of the leader-0 read replay.
    typedef struct {
        logic        l_req;
        logic        l_gnt;
        logic        l_rvalid;
        logic [31:0] l_rdata;
        logic        f1_req;
        logic        f2_req;
        logic        h1_gnt;
        logic        h1_rvalid;
        logic [31:0] h1_rdata;
        logic        h2_gnt;
        logic        h2_rvalid;
        logic [31:0] h2_rdata;
    } vec_t;

    vec_t tbl [7];

    function automatic obi_req_t mk_req(input logic req, input logic we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_t r;
        r.req   = req;
        r.we    = we;
        r.be    = be;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic obi_resp_t mk_resp(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        obi_resp_t r;
        r.gnt    = gnt;
        r.rvalid = rvalid;
        r.rdata  = rdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic idle();
        for (int h = 0; h < NH; h++) begin
            ireq_i[h]  = '0;
            dreq_i[h]  = '0;
            iresp_i[h] = '0;
            dresp_i[h] = '0;
            intr_i[h]  = '0;
        end
        dbg_i = '0;
    endtask

    // Inputs are driven 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled on the falling edge.
    task automatic half();
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'hA5A5};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0};

        // ---------------- reset ----------------
        idle();
        cyc();
        cyc();
        half();
        chk("rst_mismatch", 32'(mm), 32'h0);
        chk("rst_any", 32'(mm_any), 32'h0);
        cyc();
        rst_n = 1'b1;
        $display("reset released");

        // ---------------- bypass ----------------
        cyc();
        idle();
        ireq_i[1]  = mk_req(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        iresp_i[1] = mk_resp(1'b1, 1'b1, 32'hCAFE);
        intr_i[2]  = 32'h1234;
        half();
        chk("byp_bus1_req", 32'(ireq_o[1].req), 32'h1);
        chk("byp_bus1_addr", ireq_o[1].addr, 32'h100);
        chk("byp_core1_rvalid", 32'(iresp_o[1].rvalid), 32'h1);
        chk("byp_core1_rdata", iresp_o[1].rdata, 32'hCAFE);
        chk("byp_intr2", intr_o[2], 32'h1234);
        cyc();
        idle();
        half();
        chk("byp_mismatch", 32'(mm), 32'h0);
        $display("bypass read hart1 addr=100 rdata=%h", iresp_o[1].rdata);

        // ---------------- lockstep, leader 0, vector table ----------------
        cyc();
        idle();
        enable = 1'b1;
        leader = 2'd0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            idle();
            ireq_i[0]  = mk_req(tbl[k].l_req, 1'b0, 4'hF, 32'h200, 32'h0);
            iresp_i[0] = mk_resp(tbl[k].l_gnt, tbl[k].l_rvalid, tbl[k].l_rdata);
            ireq_i[1]  = mk_req(tbl[k].f1_req, 1'b0, 4'hF, 32'h200, 32'h0);
            ireq_i[2]  = mk_req(tbl[k].f2_req, 1'b0, 4'hF, 32'h200, 32'h0);
            iresp_i[1] = mk_resp(1'b1, 1'b1, 32'hBAD1);
            iresp_i[2] = mk_resp(1'b1, 1'b1, 32'hBAD2);
            half();
            chk($sformatf("ls%0d_h1_gnt", k), 32'(iresp_o[1].gnt), 32'(tbl[k].h1_gnt));
            chk($sformatf("ls%0d_h1_rvalid", k), 32'(iresp_o[1].rvalid), 32'(tbl[k].h1_rvalid));
            chk($sformatf("ls%0d_h1_rdata", k), iresp_o[1].rdata, tbl[k].h1_rdata);
            chk($sformatf("ls%0d_h2_gnt", k), 32'(iresp_o[2].gnt), 32'(tbl[k].h2_gnt));
            chk($sformatf("ls%0d_h2_rvalid", k), 32'(iresp_o[2].rvalid), 32'(tbl[k].h2_rvalid));
            chk($sformatf("ls%0d_h2_rdata", k), iresp_o[2].rdata, tbl[k].h2_rdata);
            chk($sformatf("ls%0d_bus0_req", k), 32'(ireq_o[0].req), 32'(tbl[k].l_req));
            chk($sformatf("ls%0d_bus1_req", k), 32'(ireq_o[1].req), 32'h0);
            chk($sformatf("ls%0d_bus2_req", k), 32'(ireq_o[2].req), 32'h0);
            chk($sformatf("ls%0d_mismatch", k), 32'(mm), 32'h0);
            $display("lockstep row %0d: h1 gnt=%0b rv=%0b  h2 gnt=%0b rv=%0b",
                     k, iresp_o[1].gnt, iresp_o[1].rvalid, iresp_o[2].gnt, iresp_o[2].rvalid);
        end

        // ---------------- divergence on data write ----------------
        cyc();
        idle();
        dreq_i[0]  = mk_req(1'b1, 1'b1, 4'hF, 32'h40, 32'h11);
        dresp_i[0] = mk_resp(1'b1, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        idle();
        dreq_i[1] = mk_req(1'b1, 1'b1, 4'hF, 32'h40, 32'h12);
        half();
        chk("div_h1_gnt", 32'(dresp_o[1].gnt), 32'h1);
        chk("div_compare_cycle", 32'(mm), 32'h0);
        cyc();
        idle();
        half();
        chk("div_set", 32'(mm), 32'h2);
        chk("div_any", 32'(mm_any), 32'h1);
        cyc();
        idle();
        dreq_i[2] = mk_req(1'b1, 1'b1, 4'hF, 32'h40, 32'h11);
        cyc();
        idle();
        clear = 1'b1;
        half();
        chk("div_h2_clean", 32'(mm), 32'h2);
        cyc();
        clear = 1'b0;
        half();
        chk("div_clear", 32'(mm), 32'h0);
        chk("div_clear_any", 32'(mm_any), 32'h0);
        $display("divergence write hart1 wdata=12 vs 11 flagged and cleared");

        // ---------------- spurious follower request ----------------
        cyc();
        idle();
        dreq_i[2] = mk_req(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        cyc();
        idle();
        dreq_i[2] = mk_req(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        clear = 1'b1;
        half();
        chk("spur_set", 32'(mm), 32'h4);
        cyc();
        idle();
        clear = 1'b1;
        half();
        chk("spur_set_wins", 32'(mm), 32'h4);
        cyc();
        clear = 1'b0;
        half();
        chk("spur_clear", 32'(mm), 32'h0);
        $display("spurious request hart2 flagged");

        // ---------------- leader rotation to hart 2 ----------------
        cyc();
        idle();
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        leader = 2'd2;
        cyc();
        idle();
        leader = 2'd0;
        dreq_i[2]  = mk_req(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        dresp_i[2] = mk_resp(1'b1, 1'b0, 32'h0);
        dbg_i[2]   = 1'b1;
        intr_i[2]  = 32'hDEAD0002;
        half();
        chk("rot_bus2_req", 32'(dreq_o[2].req), 32'h1);
        chk("rot_bus2_addr", dreq_o[2].addr, 32'h300);
        cyc();
        idle();
        dresp_i[2] = mk_resp(1'b0, 1'b1, 32'h5A);
        cyc();
        idle();
        dreq_i[0] = mk_req(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        half();
        chk("rot_h0_gnt", 32'(dresp_o[0].gnt), 32'h1);
        chk("rot_h0_debug", 32'(dbg_o[0]), 32'h1);
        chk("rot_h1_gnt_early", 32'(dresp_o[1].gnt), 32'h0);
        chk("rot_bus0_req", 32'(dreq_o[0].req), 32'h0);
        cyc();
        idle();
        half();
        chk("rot_h0_rvalid", 32'(dresp_o[0].rvalid), 32'h1);
        chk("rot_h0_rdata", dresp_o[0].rdata, 32'h5A);
        cyc();
        idle();
        dreq_i[1] = mk_req(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        half();
        chk("rot_h1_gnt", 32'(dresp_o[1].gnt), 32'h1);
        chk("rot_h1_debug", 32'(dbg_o[1]), 32'h1);
        chk("rot_h1_intr", intr_o[1], 32'hDEAD0002);
        cyc();
        idle();
        half();
        chk("rot_h1_rvalid", 32'(dresp_o[1].rvalid), 32'h1);
        chk("rot_h1_rdata", dresp_o[1].rdata, 32'h5A);
        chk("rot_mismatch", 32'(mm), 32'h0);
        $display("rotation leader=2 read addr=300 replayed to hart0 and hart1");

        // ---------------- flush on enable fall ----------------
        cyc();
        idle();
        ireq_i[2]  = mk_req(1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
        iresp_i[2] = mk_resp(1'b1, 1'b0, 32'h0);
        cyc();
        idle();
        iresp_i[2] = mk_resp(1'b0, 1'b1, 32'h77);
        enable = 1'b0;
        cyc();
        idle();
        enable = 1'b1;
        leader = 2'd2;
        for (int k = 0; k < 4; k++) begin
            cyc();
            idle();
            half();
            chk($sformatf("flush%0d_h0_gnt", k), 32'(iresp_o[0].gnt), 32'h0);
            chk($sformatf("flush%0d_h0_rvalid", k), 32'(iresp_o[0].rvalid), 32'h0);
            chk($sformatf("flush%0d_h1_gnt", k), 32'(iresp_o[1].gnt), 32'h0);
            chk($sformatf("flush%0d_h1_rvalid", k), 32'(iresp_o[1].rvalid), 32'h0);
        end
        $display("flush: no follower replay after enable drop");

        // ---------------- asynchronous reset mid-run ----------------
        cyc();
        idle();
        dreq_i[0] = mk_req(1'b1, 1'b0, 4'hF, 32'h90, 32'h0);
        cyc();
        idle();
        half();
        chk("arst_pre_mismatch", 32'(mm), 32'h1);
        #1;
        ireq_i[0] = mk_req(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_mismatch", 32'(mm), 32'h0);
        chk("arst_any", 32'(mm_any), 32'h0);
        chk("arst_bus0_req", 32'(ireq_o[0].req), 32'h1);
        chk("arst_bus0_addr", ireq_o[0].addr, 32'h500);
        #1;
        rst_n = 1'b1;
        cyc();
        idle();
        half();
        chk("arst_post_mismatch", 32'(mm), 32'h0);
        $display("async reset mid-run cleared state");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lockstep_stagger.md
# lockstep_stagger

Parametrised staggered-lockstep unit for NHARTS cores that share one OBI instruction port and one OBI data port per hart. The block sits between the cores and the bus, in the same place as the fixed two-cycle lockstep register. One hart, the leader, drives the bus with zero added latency. Every other hart, a follower of rank r, receives the leader's bus responses, interrupts and debug requests delayed by r*NCYCLES cycles. The block checks each follower's requests against the leader's delayed request stream and flags any divergence with a sticky per-hart mismatch bit.

## Interface
- NHARTS, 3: number of harts, 2..4.
- NCYCLES, 2: stagger per rank in cycles, 1..8. DMAX = (NHARTS-1)*NCYCLES.
- LW = $clog2(NHARTS): width of the leader index.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  1 = staggered lockstep, 0 = bypass.
- leader_i  in  LW  leader hart index; sampled only on the rising edge of enable_i.
- clear_i  in  1  synchronous clear of mismatch_o.
- core_instr_req_i / core_instr_req_o  in/out  obi_req_t[NHARTS]  core side / bus side.
- core_instr_resp_i / core_instr_resp_o  in/out  obi_resp_t[NHARTS]  bus side / core side.
- core_data_req_i / core_data_req_o  in/out  obi_req_t[NHARTS]  core side / bus side.
- core_data_resp_i / core_data_resp_o  in/out  obi_resp_t[NHARTS]  bus side / core side.
- intr_i / intr_o  in/out  [NHARTS][32]  interrupt lines.
- debug_i / debug_o  in/out  [NHARTS]  debug requests.
- mismatch_o  out  NHARTS  sticky divergence flag per hart.
- mismatch_any_o  out  1  OR of mismatch_o.

## Operation
- **Rank.** leader_q is a register, reset 0, loaded from leader_i in the cycle where enable_i=1 and enable_q=0. Rank of hart i: (i - leader_q) mod NHARTS.
- **Bypass (enable_q=0).**
  - All ports pass straight through, hart i to bus port i.
  - Delay lines are held at zero.
  - Mismatch flags hold their value.
- **Lockstep (enable_q=1), leader hart L.**
  - Bus port L carries core L's request and response unchanged.
  - Interrupt and debug lines for L pass through.
- **Lockstep, follower of rank r.**
  - Its bus request port drives req=0, we=0, addr/be/wdata=0. The bus never sees follower traffic.
  - Its core response is tap r*NCYCLES of the response delay line: gnt, rvalid, rdata.
  - intr_o and debug_o for the follower are tap r*NCYCLES of the intr/debug delay line, sourced from the leader's intr_i/debug_i.
- **Delay lines.**
  - One shift register per channel (instr, data), DMAX entries.
  - Each entry holds: leader handshake hs = req&gnt, we, be, addr, wdata, gnt, rvalid, rdata.
  - Stage 1 is loaded from the leader's live port values; stage k is loaded from stage k-1.
  - The tap at d means the value sampled d cycles earlier.
  - A separate DMAX-deep line carries intr (32b) and debug (1b).
- **Comparison, follower f of rank r, per channel.** When tap r*NCYCLES has hs=1, the follower is in error if any of these holds:
  - follower req=0;
  - addr differs;
  - we differs;
  - be differs;
  - we=1 and wdata differs.

  An error sets mismatch_o[f] on the next edge.
- **Spurious request.** A follower req=1 while tap hs=0 and tap gnt=0 also sets mismatch_o[f]. This covers follower requests with no matching leader handshake.
- **Mismatch register.**
  - The leader's own bit is never set.
  - clear_i=1 clears all bits. If clear_i and a new error occur in the same cycle, set wins.
- **Mode changes.**
  - enable_i falling: all delay lines are zeroed on the next edge. In-flight follower responses are dropped.
  - Software changes enable_i only with the leader idle, i.e. no outstanding transaction.
  - leader_i changes while enable_q=1 are ignored.

## Timing
- **Reset values.**
  - leader_q=0, enable_q=0, all delay stages 0, mismatch_o=0, mismatch_any_o=0.
  - Pass-through outputs follow their inputs combinationally.
- **Leader.** 0-cycle latency, purely combinational path.
- **Follower of rank r.** A bus event at cycle t appears on the follower's core port at cycle t + r*NCYCLES.
- **mismatch_o.** Registered. Asserts 1 cycle after the compare cycle; mismatch_any_o asserts in the same cycle.
- **enable_i rising at cycle t.**
  - Lockstep routing applies from t+1 (enable_q).
  - Follower taps read 0 until the delay lines fill.
- **Simultaneous divergence.** Divergence on both channels in the same cycle sets the flag once.
- **Asynchronous reset.** Reset mid-operation clears every register immediately, regardless of clock.
- **Width.** Delay-line taps are indexed by the constant r*NCYCLES ≤ DMAX. No wrap-around arithmetic.

## Test plan
- **Bypass.** NHARTS=3, enable=0, hart 1 reads 0x100 → bus port 1 req=1 in the same cycle; rdata 0xCAFE reaches core 1 in the same cycle; mismatch_o=0.
- **Lockstep, NCYCLES=2, leader 0.** Leader reads 0x200 with gnt at t and rvalid + rdata 0xA5A5 at t+1 → hart 1 sees gnt at t+2 and rdata at t+3; hart 2 sees gnt at t+4 and rdata at t+5; bus ports 1 and 2 show req=0 throughout.
- **Leader rotation.** enable rises with leader_i=2 → bus port 2 active; hart 0 is rank 1 (2-cycle delay) and hart 1 is rank 2 (4-cycle delay); a later change of leader_i to 0 has no effect.
- **Divergence.** Leader writes wdata 0x11; follower rank 1 writes 0x12 to the same address → mismatch_o=3'b010 one cycle after the compare cycle; clear_i pulse → 0.
- **Spurious request.** Follower asserts req with no leader handshake in the delay line → its mismatch bit sets.
- **Flush.** enable drops while follower responses are in flight → delay lines zero next cycle; no follower rvalid afterwards; assertion of rst_ni low mid-run → all outputs at reset values immediately.
